// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - bus widths, hold codes and state encodings for the pipeline controller
package pipe_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int HOLD_W      = 3;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
  typedef logic [HOLD_W-1:0]      hold_flag_t;

  localparam hold_flag_t HOLD_NONE = 3'd0;
  localparam hold_flag_t HOLD_PC   = 3'd1;
  localparam hold_flag_t HOLD_IF   = 3'd2;
  localparam hold_flag_t HOLD_ID   = 3'd3;

  localparam inst_addr_t ZERO_WORD = '0;
  localparam reg_addr_t  ZERO_REG  = '0;

  typedef enum logic [1:0] {
    PCTRL_RUN     = 2'd0,
    PCTRL_FLUSH   = 2'd1,
    PCTRL_MULTI   = 2'd2,
    PCTRL_LDSTALL = 2'd3
  } pctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - request/control bundle between id/ex and the pipeline controller
interface pipe_ctrl_if;

  logic                        jump_flag_i;
  pipe_ctrl_pkg::inst_addr_t   jump_addr_i;
  logic                        div_busy_i;
  logic                        hold_bus_i;
  logic                        hold_clint_i;
  logic                        ex_is_load_i;
  pipe_ctrl_pkg::reg_addr_t    ex_rd_i;
  pipe_ctrl_pkg::reg_addr_t    id_rs1_i;
  pipe_ctrl_pkg::reg_addr_t    id_rs2_i;
  logic                        id_rs1_re_i;
  logic                        id_rs2_re_i;
  pipe_ctrl_pkg::hold_flag_t   hold_flag_o;
  logic                        stall_flag_o;
  logic                        jump_flag_o;
  pipe_ctrl_pkg::inst_addr_t   jump_addr_o;

  modport master (
    output jump_flag_i, jump_addr_i, div_busy_i, hold_bus_i, hold_clint_i,
           ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
    input  hold_flag_o, stall_flag_o, jump_flag_o, jump_addr_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, div_busy_i, hold_bus_i, hold_clint_i,
           ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
    output hold_flag_o, stall_flag_o, jump_flag_o, jump_addr_o
  );

endinterface

// File: rtl/pipe_ctrl_ld_use_detect.sv
// rtl/pipe_ctrl_ld_use_detect.sv - flags an id source that depends on a load still in ex
module ld_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic      ex_is_load_i,
  input  reg_addr_t ex_rd_i,
  input  reg_addr_t id_rs1_i,
  input  reg_addr_t id_rs2_i,
  input  logic      id_rs1_re_i,
  input  logic      id_rs2_re_i,
  output logic      ld_use_o
);

  // x0 never carries a dependency, so a load targeting it needs no bubble
  assign ld_use_o = ex_is_load_i && (ex_rd_i != ZERO_REG) &&
                    ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_re_i && (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hold/stall sequencing and fetch redirect for the five-stage core
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter bit LDUSE_EN     = 1
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave ctl
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  pctrl_state_e state, state_nxt;
  logic [2:0]   fcnt, fcnt_nxt;
  logic         ld_use;
  logic         hold_req;
  hold_flag_t   hold;
  logic         stall;
  logic         jump;
  inst_addr_t   jaddr;

  ld_use_detect u_ld_use_detect (
    .ex_is_load_i (ctl.ex_is_load_i),
    .ex_rd_i      (ctl.ex_rd_i),
    .id_rs1_i     (ctl.id_rs1_i),
    .id_rs2_i     (ctl.id_rs2_i),
    .id_rs1_re_i  (ctl.id_rs1_re_i),
    .id_rs2_re_i  (ctl.id_rs2_re_i),
    .ld_use_o     (ld_use)
  );

  assign hold_req = ctl.hold_bus_i | ctl.hold_clint_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PCTRL_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    hold      = HOLD_NONE;
    stall     = 1'b0;
    jump      = 1'b0;
    jaddr     = ZERO_WORD;
    // A redirect outranks everything in every state, including a running divide
    if (ctl.jump_flag_i) begin
      jump  = 1'b1;
      jaddr = ctl.jump_addr_i;
      hold  = HOLD_ID;
      if (FLUSH_LOAD != 3'd0) begin
        state_nxt = PCTRL_FLUSH;
        fcnt_nxt  = FLUSH_LOAD;
      end else begin
        state_nxt = PCTRL_RUN;
      end
    end else begin
      unique case (state)
        PCTRL_FLUSH: begin
          hold     = HOLD_ID;
          fcnt_nxt = fcnt - 3'd1;
          if (fcnt <= 3'd1) state_nxt = PCTRL_RUN;
        end
        PCTRL_LDSTALL: begin
          state_nxt = PCTRL_RUN;
        end
        default: begin
          // MULTI shares RUN evaluation: once div drops the same cycle is re-arbitrated
          if (ctl.div_busy_i) begin
            stall     = 1'b1;
            hold      = HOLD_IF;
            state_nxt = PCTRL_MULTI;
          end else if (hold_req) begin
            hold      = HOLD_ID;
            state_nxt = PCTRL_RUN;
          end else if (LDUSE_EN && ld_use) begin
            hold      = HOLD_ID;
            state_nxt = PCTRL_LDSTALL;
          end else begin
            state_nxt = PCTRL_RUN;
          end
        end
      endcase
    end
  end

  assign ctl.hold_flag_o  = rst ? HOLD_NONE : hold;
  assign ctl.stall_flag_o = rst ? 1'b0 : stall;
  assign ctl.jump_flag_o  = rst ? 1'b0 : jump;
  assign ctl.jump_addr_o  = rst ? ZERO_WORD : jaddr;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - vector table plus corner sequences for pipe_ctrl with FLUSH_CYCLES=2
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct {
    string      name;
    logic       rst;
    logic       jump;
    inst_addr_t addr;
    logic       div;
    logic [1:0] hold;
    logic       ld;
    reg_addr_t  rd;
    reg_addr_t  rs1;
    reg_addr_t  rs2;
    logic [1:0] re;
    hold_flag_t e_hold;
    logic       e_stall;
    logic       e_jump;
    inst_addr_t e_addr;
  } vec_t;

  typedef struct {
    string      name;
    hold_flag_t hold;
    logic       stall;
    logic       jump;
    inst_addr_t addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl_if vif ();

  pipe_ctrl #(.FLUSH_CYCLES(2), .LDUSE_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (vif.slave)
  );

  function automatic vec_t mk(string name, logic r, logic j, inst_addr_t a, logic d,
                              logic [1:0] h, logic l, reg_addr_t rd, reg_addr_t rs1,
                              reg_addr_t rs2, logic [1:0] re, hold_flag_t eh,
                              logic es, logic ej, inst_addr_t ea);
    vec_t v;
    v.name = name; v.rst = r; v.jump = j; v.addr = a; v.div = d; v.hold = h;
    v.ld = l; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.re = re;
    v.e_hold = eh; v.e_stall = es; v.e_jump = ej; v.e_addr = ea;
    return v;
  endfunction

  function automatic vec_t idle(string name, hold_flag_t eh);
    return mk(name, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, eh, 0, 0, 0);
  endfunction

  task automatic check(string name, string what, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", name, what, got, want);
    end
  endtask

  task automatic step(vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = v.rst;
    vif.jump_flag_i  = v.jump;
    vif.jump_addr_i  = v.addr;
    vif.div_busy_i   = v.div;
    vif.hold_bus_i   = v.hold[1];
    vif.hold_clint_i = v.hold[0];
    vif.ex_is_load_i = v.ld;
    vif.ex_rd_i      = v.rd;
    vif.id_rs1_i     = v.rs1;
    vif.id_rs2_i     = v.rs2;
    vif.id_rs1_re_i  = v.re[0];
    vif.id_rs2_re_i  = v.re[1];
    exp_q.push_back('{v.name, v.e_hold, v.e_stall, v.e_jump, v.e_addr});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check(v.name, "scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.name, "hold_flag", 32'(vif.hold_flag_o), 32'(e.hold));
      check(e.name, "stall_flag", 32'(vif.stall_flag_o), 32'(e.stall));
      check(e.name, "jump_flag", 32'(vif.jump_flag_o), 32'(e.jump));
      check(e.name, "jump_addr", vif.jump_addr_o, e.addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    vif.jump_flag_i = 0; vif.jump_addr_i = 0; vif.div_busy_i = 0;
    vif.hold_bus_i = 0; vif.hold_clint_i = 0; vif.ex_is_load_i = 0;
    vif.ex_rd_i = 0; vif.id_rs1_i = 0; vif.id_rs2_i = 0;
    vif.id_rs1_re_i = 0; vif.id_rs2_re_i = 0;

    tbl.push_back(mk("rst0", 1, 1, 32'h55, 0, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_NONE, 0, 0, 0));
    tbl.push_back(mk("rst1", 1, 1, 32'h55, 1, 2'b11, 0, 0, 0, 0, 2'b00, HOLD_NONE, 0, 0, 0));
    tbl.push_back(idle("post_rst", HOLD_NONE));
    tbl.push_back(mk("jump", 0, 1, 32'h100, 0, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_ID, 0, 1, 32'h100));
    tbl.push_back(idle("flush1", HOLD_ID));
    tbl.push_back(idle("flush2", HOLD_ID));
    tbl.push_back(idle("flush_done", HOLD_NONE));
    tbl.push_back(mk("lduse_rs2", 0, 0, 0, 0, 2'b00, 1, 5, 0, 5, 2'b10, HOLD_ID, 0, 0, 0));
    tbl.push_back(mk("ldstall", 0, 0, 0, 0, 2'b00, 1, 5, 0, 5, 2'b10, HOLD_NONE, 0, 0, 0));
    tbl.push_back(idle("after_ldstall", HOLD_NONE));
    tbl.push_back(mk("lduse_x0", 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b10, HOLD_NONE, 0, 0, 0));
    tbl.push_back(mk("lduse_rs1", 0, 0, 0, 0, 2'b00, 1, 7, 7, 3, 2'b01, HOLD_ID, 0, 0, 0));
    tbl.push_back(idle("ldstall_rs1", HOLD_NONE));
    tbl.push_back(mk("rs1_not_read", 0, 0, 0, 0, 2'b00, 1, 7, 7, 3, 2'b10, HOLD_NONE, 0, 0, 0));
    tbl.push_back(mk("not_load", 0, 0, 0, 0, 2'b00, 0, 7, 7, 7, 2'b11, HOLD_NONE, 0, 0, 0));
    tbl.push_back(mk("hold_bus", 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 2'b00, HOLD_ID, 0, 0, 0));
    tbl.push_back(mk("div_over_clint", 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 2'b00, HOLD_IF, 1, 0, 0));
    tbl.push_back(mk("div_drop_clint", 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 2'b00, HOLD_ID, 0, 0, 0));
    tbl.push_back(mk("jump_ld", 0, 1, 32'h200, 0, 2'b00, 1, 5, 0, 5, 2'b10, HOLD_ID, 0, 1, 32'h200));
    tbl.push_back(mk("jump_ld_f1", 0, 0, 0, 0, 2'b00, 1, 5, 0, 5, 2'b10, HOLD_ID, 0, 0, 0));
    tbl.push_back(idle("jump_ld_f2", HOLD_ID));
    tbl.push_back(idle("jump_ld_done", HOLD_NONE));

    foreach (tbl[i]) step(tbl[i]);

    // Divide held for 10 cycles, releasing in the cycle busy falls
    for (int i = 0; i < 10; i++)
      step(mk($sformatf("div_%0d", i), 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_IF, 1, 0, 0));
    step(idle("div_fall", HOLD_NONE));

    // Redirect arriving in the 4th divide cycle
    for (int i = 0; i < 3; i++)
      step(mk($sformatf("mdiv_%0d", i), 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_IF, 1, 0, 0));
    step(mk("multi_jump", 0, 1, 32'h300, 1, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_ID, 0, 1, 32'h300));
    step(idle("multi_f1", HOLD_ID));
    step(idle("multi_f2", HOLD_ID));
    step(idle("multi_done", HOLD_NONE));

    // Reset mid-FLUSH, then clint competing with a load-use hazard
    step(mk("rjump", 0, 1, 32'h400, 0, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_ID, 0, 1, 32'h400));
    step(mk("rst_flush", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_NONE, 0, 0, 0));
    step(idle("rst_flush_after", HOLD_NONE));
    step(mk("clint_ld0", 0, 0, 0, 0, 2'b01, 1, 9, 9, 0, 2'b01, HOLD_ID, 0, 0, 0));
    step(mk("clint_ld1", 0, 0, 0, 0, 2'b01, 1, 9, 9, 0, 2'b01, HOLD_ID, 0, 0, 0));
    step(mk("clint_drop_ld", 0, 0, 0, 0, 2'b00, 1, 9, 9, 0, 2'b01, HOLD_ID, 0, 0, 0));
    step(mk("clint_ldstall", 0, 0, 0, 0, 2'b00, 1, 9, 9, 0, 2'b01, HOLD_NONE, 0, 0, 0));

    // Reset mid-MULTI
    step(mk("rdiv", 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_IF, 1, 0, 0));
    step(mk("rst_multi", 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 2'b00, HOLD_NONE, 0, 0, 0));
    step(idle("rst_multi_after", HOLD_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
